// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered 8:1 lane mux.
// Optional input register stage: MUX_INPUT_REG_EN.
package mux_pkg;

  localparam int N_IN = 8;
  localparam int SEL_W = 3;
  localparam logic Y_RST = 1'b0;

  function automatic logic and_or(
    input logic [N_IN-1:0] oh,
    input logic [N_IN-1:0] d
  );
    return |(oh & d);
  endfunction

endpackage

// File: rtl/mux_onehot_dec.sv
// Binary-to-one-hot decode of the lane select.
// Exactly one bit of oh is set for every s value.
module mux_onehot_dec
  import mux_pkg::*;
#(
  parameter int N_IN = mux_pkg::N_IN,
  parameter int SEL_W = mux_pkg::SEL_W
) (
  input  logic [SEL_W-1:0] s,
  output logic [N_IN-1:0]  oh
);

  // compare s against every lane index
  always_comb begin
    oh = '0;
    for (int k = 0; k < N_IN; k++) begin
      oh[k] = (s == SEL_W'(k));
    end
  end

endmodule

// File: rtl/mux.sv
// Registered 8:1 one-bit mux: one-hot decode + AND-OR.
// MUX_INPUT_REG_EN adds an input register stage (latency 2).
module mux
  import mux_pkg::*;
#(
  parameter int N_IN = mux_pkg::N_IN,
  parameter int SEL_W = mux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  d,
  input  logic [SEL_W-1:0] s,
  output logic             y
);

  logic [N_IN-1:0]  d_q;
  logic [SEL_W-1:0] s_q;
  logic [N_IN-1:0]  oh;
  logic             sel;

`ifdef MUX_INPUT_REG_EN
  // capture d and s ahead of the decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= '0;
      s_q <= '0;
    end else begin
      d_q <= d;
      s_q <= s;
    end
  end
`else
  assign d_q = d;
  assign s_q = s;
`endif

  mux_onehot_dec #(
    .N_IN (N_IN),
    .SEL_W(SEL_W)
  ) u_dec (
    .s (s_q),
    .oh(oh)
  );

  // AND-OR reduction of the decoded lanes
  always_comb begin
    sel = and_or(oh, d_q);
  end

  // output register, reset wins over update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= Y_RST;
    end else begin
      y <= sel;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: driver queues expected y,
// monitor pops one per cycle and checks mid-cycle stability.
module tb_mux;

`ifdef MUX_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic [2:0] s;
  logic       y;

  int checks;
  int fails;
  logic exp_q[$];
  logic prev_r;
  logic prev_e;
  logic done;

  mux dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .s    (s),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle of stimulus; e is hand-computed d[s]
  task automatic drive(
    input logic       r,
    input logic [7:0] dv,
    input logic [2:0] sv,
    input logic       e
  );
    logic x;
    @(negedge clk);
    rst_n = r;
    d = dv;
    s = sv;
    if (!r) x = 1'b0;
    else if (LAT == 1) x = e;
    else x = prev_r ? prev_e : 1'b0;
    exp_q.push_back(x);
    prev_r = r;
    prev_e = e;
  endtask

  // rst_n pulse between edges must not disturb y
  task automatic mid_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // monitor: check each cycle's y and its stability
  initial begin
    logic ev;
    logic last;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        checks++;
        if (y !== ev) begin
          fails++;
          $display("FAIL y_seq t=%0t actual=%b required=%b",
                   $time, y, ev);
        end
        last = y;
        #3;
        checks++;
        if (y !== last) begin
          fails++;
          $display("FAIL y_stable t=%0t actual=%b required=%b",
                   $time, y, last);
        end
      end
    end
  end

  logic [7:0] sweep_e;
  logic [7:0] tmp;

  initial begin
    checks = 0;
    fails = 0;
    done = 1'b0;
    prev_r = 1'b0;
    prev_e = 1'b0;
    rst_n = 1'b0;
    d = 8'hFF;
    s = 3'd0;
    sweep_e = 8'b01010101;

    // reset held two cycles with d[0]=1
    drive(1'b0, 8'hFF, 3'd0, 1'b1);
    drive(1'b0, 8'hFF, 3'd0, 1'b1);
    drive(1'b1, 8'hFF, 3'd0, 1'b1);
    drive(1'b1, 8'hFF, 3'd0, 1'b1);

    // sweep s over 0101_0101
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'b01010101, 3'(k), sweep_e[k]);
    end

    // walking one, matching then off-by-one select
    for (int k = 0; k < 8; k++) begin
      tmp = 8'h01 << k;
      drive(1'b1, tmp, 3'(k), 1'b1);
      drive(1'b1, tmp, 3'((k + 1) % 8), 1'b0);
    end

    // s=7 with toggling d
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k % 2 == 0) ? 8'h80 : 8'h00, 3'd7,
            (k % 2 == 0));
    end

    // hold inputs, y must hold; rst_n glitch mid-cycle
    drive(1'b1, 8'h10, 3'd4, 1'b1);
    drive(1'b1, 8'h10, 3'd4, 1'b1);
    mid_pulse();
    drive(1'b1, 8'h10, 3'd4, 1'b1);
    mid_pulse();
    drive(1'b1, 8'h10, 3'd4, 1'b1);

    // sweep interrupted by a one-cycle reset
    for (int k = 0; k < 8; k++) begin
      drive((k != 3), 8'b01010101, 3'(k), sweep_e[k]);
    end
    drive(1'b1, 8'b01010101, 3'd0, 1'b1);
    drive(1'b1, 8'b01010101, 3'd1, 1'b0);
    drive(1'b1, 8'b01010101, 3'd1, 1'b0);

    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain actual=%0d required=0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
